jt12_bus_seq: RTL

Host-side write sequencer for the JT12 CPU bus. It accepts register-write requests (part, register, value) over a valid/ready interface and buffers them in a small FIFO. It replays each request as a paced status-poll, address-write and data-write cycle on the chip's `din`/`addr`/`cs_n`/`wr_n` pins, reading `dout` for the busy flag. It sits between a host (soft CPU, VGM player, test ROM) and a jt12 instance, on the same clock and `cen`.

---
 rtl/jt12_bus_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/jt12_bus_seq.sv
// Host-side write sequencer for the JT12 CPU bus: FIFO of {part, reg, data} writes
// replayed as paced address/data strobes. Busy polling is compiled in with JT12_BUS_SEQ_BUSYPOLL_EN.
module jt12_bus_seq #(
    parameter int DEPTH   = 8,
    parameter int GAP     = 2,
    parameter int WAIT    = 32,
    parameter int BUSY_TO = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cen,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_part,
    input  logic [7:0]                 req_reg,
    input  logic [7:0]                 req_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       idle,
    output logic                       err,
    input  logic                       err_clr,
    output logic [1:0]                 addr,
    output logic [7:0]                 din,
    output logic                       cs_n,
    output logic                       wr_n,
    input  logic [7:0]                 dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
    localparam int POST_LEN = 1;
`else
    localparam int POST_LEN = WAIT;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POLL = 3'd1,
        ST_ADDR = 3'd2,
        ST_GAP  = 3'd3,
        ST_DATA = 3'd4,
        ST_POST = 3'd5
    } state_t;

    logic [16:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          push_s, pop_s;
    logic [16:0]   head_s, ent_s;

    state_t        state_r, state_s;
    logic [16:0]   hold_r, hold_s;
    logic [15:0]   cnt_r, cnt_s;
    logic          cs_n_r, cs_n_s, wr_n_r, wr_n_s;
    logic [1:0]    addr_r, addr_s;
    logic [7:0]    din_r, din_s;
    logic          err_set_s;
    logic          dout_unused_s;

    assign push_s    = req_valid && req_ready;
    assign head_s    = mem_r[rd_ptr_r];
    assign req_ready = (level_r != LW'(DEPTH));
    assign level     = level_r;
    assign idle      = (level_r == LW'(0)) && (state_r == ST_IDLE);
    assign addr      = addr_r;
    assign din       = din_r;
    assign cs_n      = cs_n_r;
    assign wr_n      = wr_n_r;

`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
    logic [7:0] busy_cnt_r, busy_cnt_s;
    logic       err_r;
    assign err           = err_r;
    assign dout_unused_s = ^dout[6:0];
`else
    assign err           = 1'b0;
    assign dout_unused_s = ^{dout, err_clr};
`endif

    // FIFO storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {req_part, req_reg, req_data};
        end
    end

    // FIFO pointers and occupancy; pushes ignore cen, pops come from the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            if (push_s && !pop_s)      level_r <= level_r + LW'(1);
            else if (!push_s && pop_s) level_r <= level_r - LW'(1);
            else                       level_r <= level_r;
        end
    end

    // Next state, then bus pins decoded from the state being entered so they leave registered
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        cnt_s     = cnt_r;
        cs_n_s    = cs_n_r;
        wr_n_s    = wr_n_r;
        addr_s    = addr_r;
        din_s     = din_r;
        pop_s     = 1'b0;
        err_set_s = 1'b0;
        ent_s     = hold_r;
`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
        busy_cnt_s = busy_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (level_r != LW'(0)) begin
                    pop_s  = cen;
                    hold_s = head_s;
                    ent_s  = head_s;
`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
                    busy_cnt_s = 8'd0;
                    state_s    = ST_POLL;
`else
                    state_s    = ST_ADDR;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
            ST_POLL: begin
                if (!dout[7]) begin
                    state_s = ST_ADDR;
                end else if (busy_cnt_r == 8'(BUSY_TO - 1)) begin
                    err_set_s = 1'b1;
                    state_s   = ST_ADDR;
                end else begin
                    busy_cnt_s = busy_cnt_r + 8'd1;
                end
            end
`endif
            ST_ADDR: begin
                cnt_s   = 16'd0;
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_r == 16'(GAP - 1)) state_s = ST_DATA;
                else                       cnt_s   = cnt_r + 16'd1;
            end
            ST_DATA: begin
                cnt_s   = 16'd0;
                state_s = ST_POST;
            end
            ST_POST: begin
                if (cnt_r == 16'(POST_LEN - 1)) state_s = ST_IDLE;
                else                            cnt_s   = cnt_r + 16'd1;
            end
            default: state_s = ST_IDLE;
        endcase

        case (state_s)
            ST_POLL: begin
                cs_n_s = 1'b0;
                wr_n_s = 1'b1;
                addr_s = 2'b00;
            end
            ST_ADDR: begin
                cs_n_s = 1'b0;
                wr_n_s = 1'b0;
                addr_s = {ent_s[16], 1'b0};
                din_s  = ent_s[15:8];
            end
            ST_DATA: begin
                cs_n_s = 1'b0;
                wr_n_s = 1'b0;
                addr_s = {ent_s[16], 1'b1};
                din_s  = ent_s[7:0];
            end
            default: begin
                cs_n_s = 1'b1;
                wr_n_s = 1'b1;
            end
        endcase
    end

    // FSM and bus pin registers, advancing only on cen edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            hold_r  <= 17'd0;
            cnt_r   <= 16'd0;
            cs_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            addr_r  <= 2'b00;
            din_r   <= 8'd0;
        end else if (cen) begin
            state_r <= state_s;
            hold_r  <= hold_s;
            cnt_r   <= cnt_s;
            cs_n_r  <= cs_n_s;
            wr_n_r  <= wr_n_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
        end
    end

`ifdef JT12_BUS_SEQ_BUSYPOLL_EN
    // Busy counter and sticky timeout flag; a timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_r <= 8'd0;
            err_r      <= 1'b0;
        end else begin
            if (cen) busy_cnt_r <= busy_cnt_s;
            if (cen && err_set_s) err_r <= 1'b1;
            else if (err_clr)     err_r <= 1'b0;
        end
    end
`endif
endmodule
